cp0_reg_unit: RTL and testbench

//  CP0 register file and exception-commit unit; the receiving end of the writeback-to-CP0 path.

---
 rtl/cp0_reg_unit.sv | 156 +++++++++++++++
 tb/tb_cp0_reg_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_reg_unit.sv
// CP0 register file and exception-commit unit at writeback: Count/Compare timer,
// interrupt pending bits, MTC0/exception/ERET commit, flush/redirect and MFC0 reads.
module cp0_reg_unit #(
    parameter int          TIMER_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_CP0Wr,
    input  logic [4:0]  WB_Dst,
    input  logic [31:0] WB_Result,
    input  logic        WB_ExcValid,
    input  logic [4:0]  WB_ExcCode,
    input  logic        WB_IsEret,
    input  logic        WB_IsFetchAdE,
    input  logic [31:0] WB_PC,
    input  logic        WB_IsInDelaySlot,
    input  logic [31:0] WB_ALUOut,
    input  logic [5:0]  Ext_Int,
    input  logic [4:0]  EXE_CP0RdAddr,
    output logic [31:0] CP0_RdData,
    output logic        CP0_Flush,
    output logic [31:0] CP0_RedirectPC,
    output logic        CP0_IntPending,
    output logic [31:0] CP0_Status,
    output logic [31:0] CP0_Cause,
    output logic [31:0] CP0_EPC
);

    localparam int DIV_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    logic [31:0] badvaddr_q, count_q, compare_q, status_q, cause_q, epc_q;
    logic [31:0] badvaddr_d, count_d, compare_d, status_d, cause_d, epc_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic        wr_ok, tick, count_upd, addr_err;
    logic [31:0] status_mtc, cause_mtc, wr_merged, rd_cur;

    assign wr_ok      = WB_CP0Wr & ~WB_ExcValid & ~WB_IsEret;
    assign status_mtc = (status_q & ~STATUS_WMASK) | (WB_Result & STATUS_WMASK);
    assign cause_mtc  = (cause_q & ~CAUSE_WMASK) | (WB_Result & CAUSE_WMASK);
    assign tick       = (div_q == DIV_W'(TIMER_DIV - 1));
    assign addr_err   = (WB_ExcCode == 5'd4) || (WB_ExcCode == 5'd5);

    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        div_d      = tick ? '0 : div_q + 1'b1;
        count_upd  = 1'b0;

        // An MTC0 Count overrides the same-cycle tick and restarts the divider.
        if (wr_ok && WB_Dst == REG_COUNT) begin
            count_d   = WB_Result;
            div_d     = '0;
            count_upd = 1'b1;
        end else if (tick) begin
            count_d   = count_q + 32'd1;
            count_upd = 1'b1;
        end

        if (wr_ok && WB_Dst == REG_COMPARE) begin
            compare_d  = WB_Result;
            cause_d[30] = 1'b0;
        end else if (count_upd && count_d == compare_q) begin
            cause_d[30] = 1'b1;
        end

        cause_d[15:10] = {Ext_Int[5] | cause_q[30], Ext_Int[4:0]};

        if (WB_ExcValid) begin
            status_d[1]   = 1'b1;
            cause_d[6:2]  = WB_ExcCode;
            if (!status_q[1]) begin
                epc_d       = WB_IsInDelaySlot ? WB_PC - 32'd4 : WB_PC;
                cause_d[31] = WB_IsInDelaySlot;
            end
            if (addr_err)
                badvaddr_d = WB_IsFetchAdE ? WB_PC : WB_ALUOut;
        end else if (WB_IsEret) begin
            status_d[1] = 1'b0;
        end else if (wr_ok) begin
            case (WB_Dst)
                REG_STATUS: status_d = status_mtc;
                REG_CAUSE:  cause_d[9:8] = WB_Result[9:8];
                REG_EPC:    epc_d = WB_Result;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            status_q   <= STATUS_RST;
            cause_q    <= '0;
            epc_q      <= '0;
            div_q      <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            div_q      <= div_d;
        end
    end

    always_comb begin
        case (EXE_CP0RdAddr)
            REG_BADVADDR: rd_cur = badvaddr_q;
            REG_COUNT:    rd_cur = count_q;
            REG_COMPARE:  rd_cur = compare_q;
            REG_STATUS:   rd_cur = status_q;
            REG_CAUSE:    rd_cur = cause_q;
            REG_EPC:      rd_cur = epc_q;
            default:      rd_cur = '0;
        endcase
    end

    // Value the register will hold after this MTC0; read-only and absent numbers keep their read value.
    always_comb begin
        case (WB_Dst)
            REG_COUNT, REG_COMPARE, REG_EPC: wr_merged = WB_Result;
            REG_STATUS: wr_merged = status_mtc;
            REG_CAUSE:  wr_merged = cause_mtc;
            default:    wr_merged = rd_cur;
        endcase
    end

    assign CP0_RdData     = (wr_ok && WB_Dst == EXE_CP0RdAddr) ? wr_merged : rd_cur;
    assign CP0_Flush      = ~rst & (WB_ExcValid | WB_IsEret);
    assign CP0_RedirectPC = WB_ExcValid ? EXC_VECTOR : epc_q;
    assign CP0_IntPending = status_q[0] & ~status_q[1] & (|(cause_q[15:8] & status_q[15:8]));
    assign CP0_Status     = status_q;
    assign CP0_Cause      = cause_q;
    assign CP0_EPC        = epc_q;

endmodule

// File: tb/tb_cp0_reg_unit.sv
// Scoreboard bench for cp0_reg_unit: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_reg_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_CP0Wr;
    logic [4:0]  WB_Dst;
    logic [31:0] WB_Result;
    logic        WB_ExcValid;
    logic [4:0]  WB_ExcCode;
    logic        WB_IsEret;
    logic        WB_IsFetchAdE;
    logic [31:0] WB_PC;
    logic        WB_IsInDelaySlot;
    logic [31:0] WB_ALUOut;
    logic [5:0]  Ext_Int;
    logic [4:0]  EXE_CP0RdAddr;
    logic [31:0] CP0_RdData;
    logic        CP0_Flush;
    logic [31:0] CP0_RedirectPC;
    logic        CP0_IntPending;
    logic [31:0] CP0_Status;
    logic [31:0] CP0_Cause;
    logic [31:0] CP0_EPC;

    cp0_reg_unit #(.TIMER_DIV(2), .EXC_VECTOR(32'hBFC0_0380)) dut (
        .clk(clk), .rst(rst),
        .WB_CP0Wr(WB_CP0Wr), .WB_Dst(WB_Dst), .WB_Result(WB_Result),
        .WB_ExcValid(WB_ExcValid), .WB_ExcCode(WB_ExcCode), .WB_IsEret(WB_IsEret),
        .WB_IsFetchAdE(WB_IsFetchAdE), .WB_PC(WB_PC), .WB_IsInDelaySlot(WB_IsInDelaySlot),
        .WB_ALUOut(WB_ALUOut), .Ext_Int(Ext_Int), .EXE_CP0RdAddr(EXE_CP0RdAddr),
        .CP0_RdData(CP0_RdData), .CP0_Flush(CP0_Flush), .CP0_RedirectPC(CP0_RedirectPC),
        .CP0_IntPending(CP0_IntPending), .CP0_Status(CP0_Status), .CP0_Cause(CP0_Cause),
        .CP0_EPC(CP0_EPC)
    );

    always #5 clk = ~clk;

    localparam int K_RD = 0, K_FLUSH = 1, K_REDIR = 2, K_INTP = 3, K_STAT = 4, K_CAUSE = 5, K_EPC = 6;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic expect_out(input string name, input int kind, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_RD:    return CP0_RdData;
            K_FLUSH: return {31'd0, CP0_Flush};
            K_REDIR: return CP0_RedirectPC;
            K_INTP:  return {31'd0, CP0_IntPending};
            K_STAT:  return CP0_Status;
            K_CAUSE: return CP0_Cause;
            default: return CP0_EPC;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e   = sb.pop_front();
            got = observe(e.kind);
            n_vec++;
            if (got !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WB_CP0Wr = 0; WB_Dst = 0; WB_Result = 0;
        WB_ExcValid = 0; WB_ExcCode = 0; WB_IsEret = 0;
        WB_IsFetchAdE = 0; WB_PC = 0; WB_IsInDelaySlot = 0; WB_ALUOut = 0;
    endtask

    task automatic mtc0(input logic [4:0] dst, input logic [31:0] data);
        idle();
        WB_CP0Wr = 1; WB_Dst = dst; WB_Result = data;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic [31:0] alu,
                       input logic fetch, input logic bd);
        idle();
        WB_ExcValid = 1; WB_ExcCode = code; WB_PC = pc; WB_ALUOut = alu;
        WB_IsFetchAdE = fetch; WB_IsInDelaySlot = bd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1; Ext_Int = 0; EXE_CP0RdAddr = 0;
        step(); step();
        rst = 0;

        // reset state
        EXE_CP0RdAddr = 12;
        expect_out("rst_rd_status", K_RD, 32'h0040_0000);
        expect_out("rst_status", K_STAT, 32'h0040_0000);
        expect_out("rst_cause", K_CAUSE, 32'h0);
        expect_out("rst_intp", K_INTP, 32'h0);
        expect_out("rst_flush", K_FLUSH, 32'h0);
        step();
        EXE_CP0RdAddr = 13;
        expect_out("rst_rd_cause", K_RD, 32'h0);
        step();

        // timer
        mtc0(12, 32'h0000_8001);
        EXE_CP0RdAddr = 12;
        expect_out("bypass_status", K_RD, 32'h0040_8001);
        step();
        mtc0(11, 32'd5); step();
        mtc0(9, 32'd0);  step();
        idle();
        EXE_CP0RdAddr = 9;
        for (int i = 0; i < 9; i++) step();
        expect_out("count_e9", K_RD, 32'd4);
        expect_out("cause_e9", K_CAUSE, 32'h0);
        step();
        expect_out("count_e10", K_RD, 32'd5);
        expect_out("cause_ti", K_CAUSE, 32'h4000_0000);
        expect_out("intp_latency", K_INTP, 32'h0);
        step();
        expect_out("cause_ip7", K_CAUSE, 32'h4000_8000);
        expect_out("intp_timer", K_INTP, 32'h1);
        step();
        mtc0(11, 32'd100);
        EXE_CP0RdAddr = 11;
        expect_out("bypass_compare", K_RD, 32'd100);
        step();
        idle();
        expect_out("ti_cleared", K_CAUSE, 32'h0000_8000);
        expect_out("intp_hold", K_INTP, 32'h1);
        step();
        expect_out("ip7_cleared", K_CAUSE, 32'h0);
        expect_out("intp_off", K_INTP, 32'h0);

        // exception in delay slot
        exc(5'd4, 32'hBFC0_0100, 32'h0000_0003, 1'b0, 1'b1);
        expect_out("exc_flush", K_FLUSH, 32'h1);
        expect_out("exc_redir", K_REDIR, 32'hBFC0_0380);
        step();
        idle();
        EXE_CP0RdAddr = 8;
        expect_out("exc_epc", K_EPC, 32'hBFC0_00FC);
        expect_out("exc_status", K_STAT, 32'h0040_8003);
        expect_out("exc_cause", K_CAUSE, 32'h8000_0010);
        expect_out("exc_badvaddr", K_RD, 32'h3);
        expect_out("exc_flush_off", K_FLUSH, 32'h0);
        expect_out("exc_intp_exl", K_INTP, 32'h0);
        step();

        // nested exception, fetch address error
        exc(5'd5, 32'h0000_1000, 32'h0000_0055, 1'b1, 1'b0);
        expect_out("nest_flush", K_FLUSH, 32'h1);
        step();
        idle();
        expect_out("nest_epc", K_EPC, 32'hBFC0_00FC);
        expect_out("nest_cause", K_CAUSE, 32'h8000_0014);
        expect_out("nest_badvaddr", K_RD, 32'h0000_1000);
        step();

        // ERET
        WB_IsEret = 1;
        expect_out("eret_flush", K_FLUSH, 32'h1);
        expect_out("eret_redir", K_REDIR, 32'hBFC0_00FC);
        step();
        idle();
        expect_out("eret_status", K_STAT, 32'h0040_8001);
        step();

        // Status write mask and suppression
        mtc0(12, 32'hFFFF_FFFF);
        EXE_CP0RdAddr = 12;
        expect_out("bypass_status_mask", K_RD, 32'h0040_FF03);
        step();
        idle();
        expect_out("status_mask", K_STAT, 32'h0040_FF03);
        step();
        exc(5'd0, 32'h0000_2000, 32'h0, 1'b0, 1'b0);
        WB_CP0Wr = 1; WB_Dst = 12; WB_Result = 32'h0;
        expect_out("suppressed_bypass", K_RD, 32'h0040_FF03);
        step();
        idle();
        expect_out("exc_drops_mtc0", K_STAT, 32'h0040_FF03);
        expect_out("exl_epc_hold", K_EPC, 32'hBFC0_00FC);
        expect_out("exl_cause", K_CAUSE, 32'h8000_0000);
        step();
        mtc0(12, 32'h0);
        WB_IsEret = 1;
        step();
        idle();
        expect_out("eret_drops_mtc0", K_STAT, 32'h0040_FF01);
        step();

        // EPC bypass, read-only and absent registers
        mtc0(14, 32'h0000_1234);
        EXE_CP0RdAddr = 14;
        expect_out("bypass_epc", K_RD, 32'h0000_1234);
        step();
        idle();
        expect_out("epc_written", K_EPC, 32'h0000_1234);
        mtc0(8, 32'hDEAD_BEEF);
        EXE_CP0RdAddr = 8;
        expect_out("badvaddr_ro_bypass", K_RD, 32'h0000_1000);
        step();
        mtc0(3, 32'hFFFF_FFFF);
        EXE_CP0RdAddr = 3;
        expect_out("absent_reg", K_RD, 32'h0);
        step();
        idle();
        EXE_CP0RdAddr = 8;
        expect_out("badvaddr_ro", K_RD, 32'h0000_1000);

        // hardware interrupt line
        Ext_Int = 6'b000001;
        expect_out("ext_latency", K_INTP, 32'h0);
        step();
        expect_out("ext_cause", K_CAUSE, 32'h8000_0400);
        expect_out("ext_intp", K_INTP, 32'h1);
        Ext_Int = 6'b000000;
        step();

        // reset mid-operation
        rst = 1;
        exc(5'd4, 32'h0000_4000, 32'h0, 1'b0, 1'b0);
        expect_out("rst_flush_gate", K_FLUSH, 32'h0);
        step();
        rst = 0;
        idle();
        EXE_CP0RdAddr = 9;
        expect_out("rst2_status", K_STAT, 32'h0040_0000);
        expect_out("rst2_cause", K_CAUSE, 32'h0);
        expect_out("rst2_epc", K_EPC, 32'h0);
        expect_out("rst2_count", K_RD, 32'h0);
        step();

        // Cause IP[1:0] write mask
        mtc0(13, 32'hFFFF_FFFF);
        EXE_CP0RdAddr = 13;
        expect_out("bypass_cause", K_RD, 32'h0000_0300);
        step();
        idle();
        expect_out("cause_sw_ip", K_CAUSE, 32'h0000_0300);
        step();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
